usonic_acq_scheduler: RTL and testbench

//  Frame-level acquisition controller for the ultrasonic ranging datapath. Each frame it drives
//  one transmitter burst, then round-robins sample slots across N_ADC SPI ADC masters. It

---
 rtl/usonic_acq_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_usonic_acq_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usonic_acq_scheduler.sv
// usonic_acq_scheduler: frame-level acquisition controller for the ultrasonic ranging path.
// Each frame drives one transmitter burst, round-robins sample slots across the SPI ADC
// masters and forwards one captured conversion per slot into the shared ADC FIFO.
// A rising FIFO-full edge halts acquisition until RST or ON=0.
// Optional build macro ACQ_CHAN_TAG_EN: tag each FIFO word with the source ADC index.
module usonic_acq_scheduler #(
  parameter int N_ADC         = 5,
  parameter int SLOT_CLKS     = 64,
  parameter int TX_HALF       = 512,
  parameter int BURST_PERIODS = 32,
  parameter int FRAME_PERIODS = 575
) (
  input  logic                CLK_40,
  input  logic                RST,
  input  logic                ON,
  input  logic [1:0]          ch_sel,
  input  logic [N_ADC-1:0]    adc_fin,
  input  logic [16*N_ADC-1:0] adc_data,
  input  logic                fifo_full,
  output logic [N_ADC-1:0]    adc_en,
  output logic [15:0]         adc_cmd,
  output logic                fifo_wr,
  output logic [15:0]         fifo_data,
  output logic                tx_p,
  output logic                tx_n,
  output logic                frame_start,
  output logic                halted
);

  localparam int PH_W   = $clog2(2 * TX_HALF);
  localparam int PER_W  = $clog2(FRAME_PERIODS + 1);
  localparam int SLOT_W = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam int IDX_W  = 3;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * TX_HALF - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(TX_HALF);
  localparam logic [PER_W-1:0]  PER_BURST = PER_W'(BURST_PERIODS);
  localparam logic [PER_W-1:0]  PER_FRAME = PER_W'(FRAME_PERIODS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CLKS - 1);
  localparam logic [SLOT_W-1:0] EN_CLKS   = SLOT_W'(3 * SLOT_CLKS / 4);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ADC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_LISTEN, S_HALT} state_t;

  state_t              state_q, state_nxt;
  logic                frame_start_nxt;
  logic [PH_W-1:0]     phase_q, phase_nxt;
  logic [PER_W-1:0]    period_q, period_nxt, period_inc;
  logic [SLOT_W-1:0]   slot_q, slot_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                slot_hit_q, slot_hit_nxt;
  logic [N_ADC-1:0]    fin_prev;
  logic                full_prev;
  logic                active_q, active_nxt, ph_wrap, slot_end, full_rise, edge_ok;
  logic [N_ADC-1:0]    adc_en_nxt;
  logic                vld_p0;
  logic [15:0]         data_p0;

  // Packs a raw 16-bit conversion into the FIFO word format.
`ifdef ACQ_CHAN_TAG_EN
  function automatic logic [15:0] pack_sample(input logic [15:0] raw, input logic [IDX_W-1:0] tag);
    pack_sample = {tag, 13'(raw >> 1)};
  endfunction
`else
  function automatic logic [15:0] pack_sample(input logic [15:0] raw);
    pack_sample = raw >> 1;
  endfunction
`endif

  assign adc_cmd    = {4'b0001, 1'b1, 2'b00, ch_sel, 7'b1000000};
  assign halted     = (state_q == S_HALT);
  assign active_q   = (state_q == S_BURST) || (state_q == S_LISTEN);
  assign active_nxt = (state_nxt == S_BURST) || (state_nxt == S_LISTEN);
  assign ph_wrap    = (phase_q == PH_LAST);
  assign slot_end   = (slot_q == SLOT_LAST);
  assign period_inc = period_q + 1'b1;
  assign full_rise  = fifo_full && !full_prev;
  // A write is taken only from the selected ADC, once per slot, while acquisition continues.
  assign edge_ok    = active_q && active_nxt && !slot_hit_q && adc_fin[idx_q] && !fin_prev[idx_q];
  assign adc_en_nxt = (active_nxt && (slot_nxt < EN_CLKS)) ? (N_ADC'(1) << idx_nxt) : '0;

  // FSM state register
  always_ff @(posedge CLK_40) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic: frame sequencing, overflow halt, ON override
  always_comb begin
    state_nxt       = state_q;
    frame_start_nxt = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_nxt       = S_BURST;
        frame_start_nxt = 1'b1;
      end
      S_BURST: begin
        if (full_rise)                             state_nxt = S_HALT;
        else if (ph_wrap && period_inc == PER_BURST) state_nxt = S_LISTEN;
      end
      S_LISTEN: begin
        if (full_rise) state_nxt = S_HALT;
        else if (ph_wrap && period_inc == PER_FRAME) begin
          state_nxt       = S_BURST;
          frame_start_nxt = 1'b1;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (!ON) begin
      state_nxt       = S_IDLE;
      frame_start_nxt = 1'b0;
    end
  end

  // Carrier phase, period, slot and ADC index counters; all clear whenever acquisition stops
  always_comb begin
    phase_nxt    = '0;
    period_nxt   = '0;
    slot_nxt     = '0;
    idx_nxt      = '0;
    slot_hit_nxt = 1'b0;
    if (active_q && active_nxt) begin
      phase_nxt    = ph_wrap ? '0 : phase_q + 1'b1;
      period_nxt   = ph_wrap ? ((period_inc == PER_FRAME) ? '0 : period_inc) : period_q;
      slot_nxt     = slot_end ? '0 : slot_q + 1'b1;
      idx_nxt      = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
      slot_hit_nxt = slot_end ? 1'b0 : (slot_hit_q || edge_ok);
    end
  end

  // Counter registers and input edge history
  always_ff @(posedge CLK_40) begin
    if (RST) begin
      phase_q    <= '0;
      period_q   <= '0;
      slot_q     <= '0;
      idx_q      <= '0;
      slot_hit_q <= 1'b0;
      fin_prev   <= '0;
      full_prev  <= 1'b0;
    end else begin
      phase_q    <= phase_nxt;
      period_q   <= period_nxt;
      slot_q     <= slot_nxt;
      idx_q      <= idx_nxt;
      slot_hit_q <= slot_hit_nxt;
      fin_prev   <= adc_fin;
      full_prev  <= fifo_full;
    end
  end

  // ---- stage p0: edge register (capture valid) ----
  // Capture valid flag
  always_ff @(posedge CLK_40) begin
    if (RST) vld_p0 <= 1'b0;
    else     vld_p0 <= edge_ok;
  end

  // Captured sample word, loaded on an accepted edge
  always_ff @(posedge CLK_40) begin
    if (edge_ok) begin
`ifdef ACQ_CHAN_TAG_EN
      data_p0 <= pack_sample(adc_data[16*idx_q +: 16], idx_q);
`else
      data_p0 <= pack_sample(adc_data[16*idx_q +: 16]);
`endif
    end
  end

  // ---- stage p1: output register ----
  // Registered outputs; a pending write is dropped on full, halt or stop
  always_ff @(posedge CLK_40) begin
    if (RST) begin
      fifo_wr     <= 1'b0;
      fifo_data   <= '0;
      adc_en      <= '0;
      tx_p        <= 1'b0;
      tx_n        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      fifo_wr     <= vld_p0 && !fifo_full && active_nxt;
      if (vld_p0 && !fifo_full && active_nxt) fifo_data <= data_p0;
      adc_en      <= adc_en_nxt;
      tx_p        <= (state_nxt == S_BURST) && (phase_nxt >= PH_HALF);
      tx_n        <= (state_nxt == S_BURST) && (phase_nxt < PH_HALF);
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_usonic_acq_scheduler.sv
// tb_usonic_acq_scheduler: directed sequence with randomized ADC traffic, checked against
// a cycle-count reference model of frame timing, slot rotation and FIFO writes.
`timescale 1ns/1ps
module tb_usonic_acq_scheduler;
  localparam int N          = 5;
  localparam int SLOT       = 64;
  localparam int TXH        = 32;
  localparam int BP         = 4;
  localparam int FP         = 12;
  localparam int FRAME_CLKS = FP * 2 * TXH;
  localparam int BURST_CLKS = BP * 2 * TXH;
  localparam int EN_CLKS    = 3 * SLOT / 4;

  logic           CLK_40 = 1'b0;
  logic           RST, ON, fifo_full;
  logic [1:0]     ch_sel;
  logic [N-1:0]   adc_fin;
  logic [16*N-1:0] adc_data;
  logic [N-1:0]   adc_en;
  logic [15:0]    adc_cmd, fifo_data;
  logic           fifo_wr, tx_p, tx_n, frame_start, halted;

  usonic_acq_scheduler #(
    .N_ADC(N), .SLOT_CLKS(SLOT), .TX_HALF(TXH), .BURST_PERIODS(BP), .FRAME_PERIODS(FP)
  ) dut (
    .CLK_40(CLK_40), .RST(RST), .ON(ON), .ch_sel(ch_sel), .adc_fin(adc_fin),
    .adc_data(adc_data), .fifo_full(fifo_full), .adc_en(adc_en), .adc_cmd(adc_cmd),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .tx_p(tx_p), .tx_n(tx_n),
    .frame_start(frame_start), .halted(halted)
  );

  always #12.5 CLK_40 = ~CLK_40;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          run = 1'b0, halt_m = 1'b0, directed = 1'b0, noise = 1'b0;
  int          t = 0, last_wr_slot = -1, cur_s = -1, mode = 0, o1 = 0, o2 = 0;
  int          wr_seen = 0, fs_cnt = 0, wr_mark = 0;
  logic [N-1:0] fin_prev_m = '0;
  bit          full_prev_m = 1'b0;
  int          exp_t[$];
  logic [15:0] exp_d[$];
  logic [15:0] rr_tab [5] = '{16'h0918, 16'h0918, 16'h0919, 16'h0919, 16'h091A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] raw, input int src);
`ifdef ACQ_CHAN_TAG_EN
    exp_word = {3'(src), raw[13:1]};
`else
    exp_word = {1'b0, raw[15:1]};
`endif
  endfunction

  task automatic clear_q();
    exp_t.delete();
    exp_d.delete();
  endtask

  // Drive ADC levels/data for the current cycle and predict resulting writes.
  task automatic drive();
    int s, off, sel;
    logic [N-1:0] v;
    logic [16*N-1:0] d;
    bit lvl, will_run;
    v = '0; d = '0; s = 0; sel = 0;
    for (int i = 0; i < N; i++) d[16*i +: 16] = directed ? 16'(16'h1230 + i) : 16'($urandom);
    if (run) begin
      s = t / SLOT; off = t % SLOT; sel = s % N;
      if (s != cur_s) begin
        cur_s = s;
        if (directed) begin
          mode = (s == 2) ? 1 : ((s == 3) ? 2 : 0);
          o1 = 40; o2 = 44;
        end else begin
          mode = int'($urandom_range(0, 2));
          o1 = int'($urandom_range(1, 30));
          o2 = int'($urandom_range(o1 + 6, 58));
        end
      end
      if (noise) v = N'($urandom);
      lvl = ((mode != 1) && (off >= o1) && (off < o1 + 3)) ||
            ((mode == 2) && (off >= o2) && (off < o2 + 3));
      v[sel] = lvl;
    end
    ch_sel   = 2'($urandom);
    adc_fin  = v;
    adc_data = d;
    will_run = run && !halt_m && !RST && ON && !(fifo_full && !full_prev_m);
    if (will_run && v[sel] && !fin_prev_m[sel] && last_wr_slot != s) begin
      exp_t.push_back(t + 2);
      exp_d.push_back(exp_word(d[16*sel +: 16], sel));
      last_wr_slot = s;
    end
    fin_prev_m = RST ? '0 : v;
  endtask

  // Advance one clock, update the model from the sampled controls, check every output.
  task automatic tick();
    logic [N-1:0] en_e;
    bit fs_e, txp_e, txn_e, wr_e;
    logic [15:0] d_e;
    int f, ph, ix, s;
    @(posedge CLK_40);
    #1;
    if (RST || !ON) begin
      run = 1'b0; halt_m = 1'b0; clear_q();
    end else if (halt_m) begin
      run = 1'b0;
    end else if (run && fifo_full && !full_prev_m) begin
      halt_m = 1'b1; run = 1'b0; clear_q();
    end else if (run) begin
      t++;
    end else begin
      run = 1'b1; t = 0; cur_s = -1; last_wr_slot = -1;
    end
    full_prev_m = RST ? 1'b0 : fifo_full;

    en_e = '0; fs_e = 1'b0; txp_e = 1'b0; txn_e = 1'b0;
    if (run) begin
      f  = t % FRAME_CLKS;
      ph = t % (2 * TXH);
      ix = (t / SLOT) % N;
      fs_e  = (f == 0);
      txp_e = (f < BURST_CLKS) && (ph >= TXH);
      txn_e = (f < BURST_CLKS) && (ph < TXH);
      if ((t % SLOT) < EN_CLKS) en_e[ix] = 1'b1;
    end
    wr_e = 1'b0; d_e = '0;
    if (exp_t.size() > 0 && exp_t[0] == t) begin
      wr_e = !fifo_full;
      d_e  = exp_d[0];
      void'(exp_t.pop_front());
      void'(exp_d.pop_front());
    end

    chk("adc_en", 32'(adc_en), 32'(en_e));
    chk("frame_start", 32'(frame_start), 32'(fs_e));
    chk("tx_p", 32'(tx_p), 32'(txp_e));
    chk("tx_n", 32'(tx_n), 32'(txn_e));
    chk("halted", 32'(halted), 32'(halt_m));
    chk("fifo_wr", 32'(fifo_wr), 32'(wr_e));
    chk("adc_cmd", 32'(adc_cmd), 32'(16'h1840) + 32'(ch_sel) * 128);
    if (frame_start) fs_cnt++;
    if (wr_e && fifo_wr) begin
      wr_seen++;
      chk("fifo_data", 32'(fifo_data), 32'(d_e));
      if (directed) begin
        s = (t - 2) / SLOT;
`ifdef ACQ_CHAN_TAG_EN
        chk("rr_tag", 32'(fifo_data[15:13]), 32'(s % N));
`else
        chk("rr_data", 32'(fifo_data), 32'(rr_tab[s % N]));
`endif
      end
    end
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  initial begin
    RST = 1'b1; ON = 1'b0; fifo_full = 1'b0; ch_sel = 2'd0; adc_fin = '0; adc_data = '0;

    // reset then idle with ON low
    repeat (4) step();
    RST = 1'b0;
    repeat (1000) step();

    // directed round-robin, slot 2 missing fin, slot 3 duplicate fin
    directed = 1'b1; noise = 1'b0; wr_seen = 0;
    ON = 1'b1;
    step();
    chk("first_frame_start", 32'(frame_start), 32'd1);
    chk("first_adc_en", 32'(adc_en), 32'd1);
    repeat (10 * SLOT - 1) step();
    chk("rr_write_count", 32'(wr_seen), 32'd9);

    // randomized traffic with noise on unselected ADCs across frame boundaries
    directed = 1'b0; noise = 1'b1; fs_cnt = 0;
    repeat (1600) step();
    chk("frame_count", 32'(fs_cnt), 32'd2);

    // ON falls while a write is pending
    for (int k = 0; k < 400 && exp_t.size() == 0; k++) step();
    ON = 1'b0;
    step();
    chk("on_fall_en", 32'(adc_en), 32'd0);
    repeat (20) step();

    // overflow mid-LISTEN with a write pending
    ON = 1'b1;
    repeat (BURST_CLKS + 100) step();
    for (int k = 0; k < 400 && exp_t.size() == 0; k++) step();
    fifo_full = 1'b1;
    step();
    chk("halt_entered", 32'(halted), 32'd1);
    repeat (50) step();
    fifo_full = 1'b0;
    repeat (50) step();
    chk("halt_sticky", 32'(halted), 32'd1);
    ON = 1'b0;
    step();
    chk("halt_cleared", 32'(halted), 32'd0);
    ON = 1'b1;
    step();
    chk("restart_frame_start", 32'(frame_start), 32'd1);
    chk("restart_idx0", 32'(adc_en), 32'd1);
    repeat (300) step();

    // FIFO already full before start: no rise, so no halt, but writes suppressed
    ON = 1'b0;
    step();
    fifo_full = 1'b1;
    step();
    ON = 1'b1;
    wr_mark = wr_seen;
    repeat (5 * SLOT) step();
    chk("full_no_halt", 32'(halted), 32'd0);
    chk("full_no_writes", 32'(wr_seen - wr_mark), 32'd0);
    fifo_full = 1'b0;
    repeat (3 * SLOT) step();

    // reset wins over a running acquisition
    RST = 1'b1;
    step();
    chk("rst_wins_en", 32'(adc_en), 32'd0);
    chk("rst_wins_wr", 32'(fifo_wr), 32'd0);
    RST = 1'b0;
    step();
    chk("post_rst_start", 32'(frame_start), 32'd1);
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
